// File: rtl/adder_sequencer.sv
// Multi-nibble add/subtract sequencer that reuses one 4-bit ripple-carry adder, LSB nibble first.
// Optional subtraction is built only when ADDER_SEQUENCER_SUB_EN is defined.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

module adder_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           accept;

  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           carry;
  logic [IW-1:0]  idx;
  logic           last;

  logic [W-1:0]   b_in;
  logic           carry_in;

  logic [3:0]     a_nib;
  logic [3:0]     b_nib;
  logic [3:0]     sum_nib;
  logic           add_cout;

`ifdef ADDER_SEQUENCER_SUB_EN
  // Subtraction is A + ~B + 1; cin is deliberately ignored in that mode.
  assign b_in     = sub ? ~op_b : op_b;
  assign carry_in = sub | cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in       = op_b;
  assign carry_in   = cin;
`endif

  assign a_nib = a_reg[4*idx +: 4];
  assign b_nib = b_reg[4*idx +: 4];
  assign last  = (idx == IW'(NIBBLES - 1));

  ripple_carry_adder u_rca (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (sum_nib),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Flags come from the top nibble only; the idx wrap keeps the nibble select in range outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_reg  <= op_a;
      b_reg  <= b_in;
      carry  <= carry_in;
      idx    <= '0;
      result <= '0;
    end else if (state == RUN) begin
      result[4*idx +: 4] <= sum_nib;
      carry              <= add_cout;
      idx                <= last ? '0 : idx + 1'b1;
      if (last) begin
        cout     <= add_cout;
        overflow <= (a_nib[3] == b_nib[3]) && (sum_nib[3] != a_nib[3]);
      end
    end
  end

endmodule
